// File: rtl/vline_dbuffer.sv
// Ping-pong scanline buffer: the fetch side fills the back bank while the display reads the front bank.
// The banks swap on LineSwap only once the back line is complete; otherwise the front line replays.
module vline_dbuffer #(
    parameter int AWIDTH                = 8,
    parameter int BPP                   = 6,
    parameter int PSIZE                 = 256,
    parameter logic [BPP-1:0] BLANK_COLOR = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteValid,
    input  logic [BPP-1:0]    DataIn,
    output logic              WriteReady,
    input  logic              LineSwap,
    input  logic              Blank,
    input  logic [AWIDTH-1:0] ReadAddress,
    output logic [BPP-1:0]    VideoOut,
    output logic              FrontValid,
    output logic              Underrun
);
    localparam int PW = (PSIZE > 1) ? $clog2(PSIZE) : 1;

    typedef struct packed {
        logic           vld;
        logic [PW-1:0]  idx;
        logic [BPP-1:0] data;
    } wr_req_t;

    logic [BPP-1:0] bank [2][PSIZE];
    logic           front_sel;
    logic [PW-1:0]  wptr;
    logic           back_full;
    logic           addr_oob;
    logic           swap_take;
    wr_req_t        wr;

    assign WriteReady = !back_full;
    assign swap_take  = LineSwap && back_full;

    always_comb begin
        wr      = '0;
        wr.vld  = WriteValid && !back_full;
        wr.idx  = wptr;
        wr.data = DataIn;
    end

    // A full-range address port can never point past the line.
    generate
        if (PSIZE < (2 ** AWIDTH)) begin : g_oob
            assign addr_oob = (ReadAddress >= AWIDTH'(PSIZE));
        end else begin : g_no_oob
            assign addr_oob = 1'b0;
        end
    endgenerate

    // Bank storage carries no reset; FrontValid gates any stale contents.
    always_ff @(posedge Clk) begin
        if (wr.vld)
            bank[!front_sel][wr.idx] <= wr.data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            front_sel  <= 1'b0;
            wptr       <= '0;
            back_full  <= 1'b0;
            FrontValid <= 1'b0;
            VideoOut   <= BLANK_COLOR;
            Underrun   <= 1'b0;
        end else begin
            Underrun <= LineSwap && !back_full;

            // A write and a taking swap are mutually exclusive: both depend on back_full.
            if (swap_take) begin
                front_sel  <= !front_sel;
                back_full  <= 1'b0;
                FrontValid <= 1'b1;
            end else if (wr.vld) begin
                if (wptr == PW'(PSIZE - 1)) begin
                    wptr      <= '0;
                    back_full <= 1'b1;
                end else begin
                    wptr <= wptr + PW'(1);
                end
            end

            if (Blank || !FrontValid || addr_oob)
                VideoOut <= BLANK_COLOR;
            else
                VideoOut <= bank[front_sel][ReadAddress[PW-1:0]];
        end
    end
endmodule

// File: tb/tb_vline_dbuffer.sv
// Directed bench for vline_dbuffer with a 4-pixel line and 6-bit pixels.
module tb_vline_dbuffer;
    localparam int AWIDTH = 8;
    localparam int BPP    = 6;
    localparam int PSIZE  = 4;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              WriteValid;
    logic [BPP-1:0]    DataIn;
    logic              WriteReady;
    logic              LineSwap;
    logic              Blank;
    logic [AWIDTH-1:0] ReadAddress;
    logic [BPP-1:0]    VideoOut;
    logic              FrontValid;
    logic              Underrun;

    int checks   = 0;
    int failures = 0;

    vline_dbuffer #(.AWIDTH(AWIDTH), .BPP(BPP), .PSIZE(PSIZE), .BLANK_COLOR('0)) dut (
        .Clk(Clk), .Reset(Reset), .WriteValid(WriteValid), .DataIn(DataIn),
        .WriteReady(WriteReady), .LineSwap(LineSwap), .Blank(Blank),
        .ReadAddress(ReadAddress), .VideoOut(VideoOut), .FrontValid(FrontValid),
        .Underrun(Underrun)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_px(input logic [BPP-1:0] d);
        WriteValid = 1'b1;
        DataIn     = d;
        step();
        WriteValid = 1'b0;
    endtask

    task automatic rd(input logic [AWIDTH-1:0] a, input logic [BPP-1:0] exp, input string tag);
        ReadAddress = a;
        step();
        chk(tag, 32'(VideoOut), 32'(exp));
    endtask

    task automatic swap();
        LineSwap = 1'b1;
        step();
        LineSwap = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; WriteValid = 1'b0; DataIn = '0; LineSwap = 1'b0;
        Blank = 1'b0; ReadAddress = 8'd2;
        step();
        step();
        // 1: reset state
        chk("rst_video", 32'(VideoOut), 32'h0);
        chk("rst_fvalid", 32'(FrontValid), 32'h0);
        chk("rst_wready", 32'(WriteReady), 32'h1);
        chk("rst_underrun", 32'(Underrun), 32'h0);
        Reset = 1'b0;
        rd(8'd2, 6'h00, "rst_read_blank");

        // 2: fill, swap, read back
        for (int i = 0; i < 4; i++) begin
            WriteValid = 1'b1; DataIn = 6'(i + 1);
            step();
        end
        WriteValid = 1'b0;
        chk("t2_wready_full", 32'(WriteReady), 32'h0);
        swap();
        chk("t2_fvalid", 32'(FrontValid), 32'h1);
        chk("t2_underrun", 32'(Underrun), 32'h0);
        rd(8'd0, 6'h01, "t2_rd0");
        rd(8'd1, 6'h02, "t2_rd1");
        rd(8'd2, 6'h03, "t2_rd2");
        rd(8'd3, 6'h04, "t2_rd3");

        // 3: full back bank ignores writes; first post-swap write lands at index 0
        wr_px(6'h11); wr_px(6'h12); wr_px(6'h13); wr_px(6'h14);
        WriteValid = 1'b1; DataIn = 6'h3F; ReadAddress = 8'd0;
        step();
        chk("t3_wready_hold0", 32'(WriteReady), 32'h0);
        chk("t3_front_kept", 32'(VideoOut), 32'h01);
        step();
        chk("t3_wready_hold1", 32'(WriteReady), 32'h0);
        swap();
        chk("t3_swap_old_front", 32'(VideoOut), 32'h01);
        chk("t3_wready_after", 32'(WriteReady), 32'h1);
        step();
        WriteValid = 1'b0;
        chk("t3_new_front0", 32'(VideoOut), 32'h11);
        rd(8'd3, 6'h14, "t3_new_front3");
        wr_px(6'h21); wr_px(6'h22); wr_px(6'h23);
        chk("t3_full_again", 32'(WriteReady), 32'h0);
        swap();
        rd(8'd0, 6'h3F, "t3_idx0_3f");
        rd(8'd1, 6'h21, "t3_idx1");
        rd(8'd3, 6'h23, "t3_idx3");

        // 4: underrun keeps fill progress and replays the front line
        wr_px(6'h31); wr_px(6'h32);
        ReadAddress = 8'd2;
        swap();
        chk("t4_underrun_pulse", 32'(Underrun), 32'h1);
        chk("t4_replay0", 32'(VideoOut), 32'h22);
        step();
        chk("t4_underrun_drop", 32'(Underrun), 32'h0);
        chk("t4_replay1", 32'(VideoOut), 32'h22);
        wr_px(6'h33); wr_px(6'h34);
        chk("t4_full", 32'(WriteReady), 32'h0);
        swap();
        chk("t4_no_underrun", 32'(Underrun), 32'h0);
        rd(8'd0, 6'h31, "t4_rd0");
        rd(8'd2, 6'h33, "t4_rd2");
        rd(8'd3, 6'h34, "t4_rd3");

        // 5: final write coinciding with LineSwap is an underrun
        wr_px(6'h41); wr_px(6'h42); wr_px(6'h43);
        WriteValid = 1'b1; DataIn = 6'h44; LineSwap = 1'b1; ReadAddress = 8'd0;
        step();
        WriteValid = 1'b0; LineSwap = 1'b0;
        chk("t5_underrun", 32'(Underrun), 32'h1);
        chk("t5_full", 32'(WriteReady), 32'h0);
        chk("t5_old0", 32'(VideoOut), 32'h31);
        step();
        chk("t5_no_swap", 32'(VideoOut), 32'h31);
        swap();
        chk("t5_swap_ok", 32'(Underrun), 32'h0);
        rd(8'd3, 6'h44, "t5_rd3");
        rd(8'd0, 6'h41, "t5_rd0");

        // 6: blanking, out-of-range addresses, reset mid-fill
        Blank = 1'b1;
        rd(8'd1, 6'h00, "t6_blank");
        Blank = 1'b0;
        rd(8'd1, 6'h42, "t6_unblank");
        rd(8'd4, 6'h00, "t6_oob4");
        rd(8'hFF, 6'h00, "t6_oobff");
        rd(8'd2, 6'h43, "t6_inrange");
        wr_px(6'h51); wr_px(6'h52);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("t6_rst_video", 32'(VideoOut), 32'h0);
        chk("t6_rst_fvalid", 32'(FrontValid), 32'h0);
        chk("t6_rst_wready", 32'(WriteReady), 32'h1);
        rd(8'd2, 6'h00, "t6_rst_blank");
        wr_px(6'h21); wr_px(6'h22); wr_px(6'h23);
        chk("t6_ptr_restart", 32'(WriteReady), 32'h1);
        wr_px(6'h24);
        chk("t6_full", 32'(WriteReady), 32'h0);
        swap();
        rd(8'd0, 6'h21, "t6_rd0");
        rd(8'd3, 6'h24, "t6_rd3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
